count_monitor: RTL
==================

COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter ERR_W, default 8: width of the saturating error counter.
REQ-002 Parameter LOCK_CYCLES, default 2: consecutive matches RESYNC needs to return to TRACK; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  monitoring enable.
REQ-006 dut_rst_n  input  1  reset applied to the observed 8-bit up/down counter in the same cycle.
REQ-007 down  input  1  direction applied to the observed counter in the same cycle (1 = decrement).
REQ-008 count  input  8  observed counter output.
REQ-009 expected  output  8  predicted value of count for the next edge.
REQ-010 locked  output  1  high while in TRACK.
REQ-011 mismatch  output  1  one-cycle pulse on a detected prediction failure.
REQ-012 err_sticky  output  1  set on first mismatch, cleared only by reset.
REQ-013 err_cnt  output  ERR_W  saturating mismatch count.
REQ-014 wrap_up  output  1  one-cycle pulse on a verified 255->0 increment.
REQ-015 wrap_dn  output  1  one-cycle pulse on a verified 0->255 decrement.

Function
REQ-016 Prediction: at every edge with en=1, expected SHALL load 0 if dut_rst_n=0, else count-1 if down=1, else count+1, all modulo 256.
REQ-017 Compare: at edge k+1, count(k+1) SHALL be compared against expected loaded at edge k; compare result and outputs are registered, visible after edge k+1.
REQ-018 FSM states: IDLE, SYNC, TRACK, RESYNC; encoding is free.
REQ-019 IDLE: no compare; en=1 -> SYNC with expected loaded per REQ-016.
REQ-020 SYNC: match -> TRACK; miss -> stay SYNC; a SYNC miss SHALL NOT assert mismatch or change err_cnt.
REQ-021 TRACK: match -> stay; miss -> RESYNC, mismatch=1 for one cycle, err_cnt+1, err_sticky=1.
REQ-022 RESYNC: LOCK_CYCLES consecutive matches -> TRACK; any miss restarts the match run without further error counting.
REQ-023 en=0 at any edge: next state IDLE, locked=0; expected, err_cnt and err_sticky hold.
REQ-024 err_cnt SHALL saturate at 2^ERR_W-1; no wrap.
REQ-025 wrap_up SHALL pulse only on a TRACK match where the previous sample was 255, down=0 and dut_rst_n=1; wrap_dn only on a TRACK match with previous sample 0, down=1 and dut_rst_n=1.
REQ-026 mismatch, wrap_up and wrap_dn SHALL be mutually exclusive and never high for more than one consecutive cycle from a single event.
REQ-027 locked SHALL be a registered decode of state==TRACK.
REQ-028 Simultaneous en falling and a miss on the same edge: en wins; no error counted.

Reset
REQ-029 rst_n=0 at an edge SHALL force state IDLE, expected=0, locked=0, mismatch=0, err_sticky=0, err_cnt=0, wrap_up=0, wrap_dn=0, overriding en and all other inputs.
REQ-030 rst_n asserted mid-TRACK SHALL discard the pending compare; the first compare after release follows REQ-019.
REQ-031 dut_rst_n is data, not a reset of this block: it only affects prediction per REQ-016.

Verification
REQ-032 Lock-in: rst_n released, en=1, counter reset then counting up from 0 -> locked=1 two edges after en, expected tracks count+1, err_cnt=0.
REQ-033 Direction change: up to 3, down=1 for 3 cycles, then down=0 -> counts 3,2,1,0,1 match; no mismatch, locked stays 1.
REQ-034 Wrap: count up 254,255,0 then down 0,255 -> wrap_up one pulse after 0 sampled, wrap_dn one pulse after 255 sampled.
REQ-035 Fault: in TRACK force count 5 when 8 expected -> mismatch one cycle, err_cnt=1, err_sticky=1, locked=0; clean sequence resumes -> locked=1 after LOCK_CYCLES (2) matches.
REQ-036 Saturation/reset: ERR_W=2, inject 5 TRACK faults -> err_cnt=3 held; rst_n=0 one edge -> all outputs 0, state IDLE.
REQ-037 DUT reset mid-run: dut_rst_n=0 one cycle at count=0x40 -> expected=0, next count 0 matches, no mismatch.

Source files
------------

// File: rtl/count_monitor.sv
// count_monitor: predicts the next value of an external 8-bit up/down
// counter from its reset/direction inputs and checks every following
// sample against that prediction. Lock state, error statistics and
// verified wrap events are reported on registered outputs.

module count_monitor #(
  parameter int ERR_W       = 8,
  parameter int LOCK_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dut_rst_n,
  input  logic             down,
  input  logic [7:0]       count,
  output logic [7:0]       expected,
  output logic             locked,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic             wrap_up,
  output logic             wrap_dn
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_TRACK  = 2'd2,
    ST_RESYNC = 2'd3
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CYCLES);

  state_t           state_r;
  logic [3:0]       run_r;
  logic [7:0]       prev_count_r;
  logic             prev_down_r;
  logic             prev_dut_rst_n_r;

  logic [7:0]       pred_s;
  logic             hit_s;
  logic [ERR_W-1:0] err_inc_s;
  logic [3:0]       run_inc_s;
  logic             wrap_up_hit_s;
  logic             wrap_dn_hit_s;
  logic             state_is_track_s;

  // Next-value prediction, compare result and saturating error increment.
  always_comb begin
    pred_s        = 8'd0;
    hit_s         = 1'b0;
    err_inc_s     = err_cnt;
    run_inc_s     = run_r + 4'd1;
    wrap_up_hit_s = 1'b0;
    wrap_dn_hit_s = 1'b0;

    if (!dut_rst_n) begin
      pred_s = 8'd0;
    end else if (down) begin
      pred_s = count - 8'd1;
    end else begin
      pred_s = count + 8'd1;
    end

    hit_s = (count == expected);

    if (err_cnt == ERR_MAX) begin
      err_inc_s = err_cnt;
    end else begin
      err_inc_s = err_cnt + ERR_ONE;
    end

    // A wrap is only credited when the previous edge really asked for it.
    wrap_up_hit_s = hit_s && (prev_count_r == 8'hFF) && !prev_down_r && prev_dut_rst_n_r;
    wrap_dn_hit_s = hit_s && (prev_count_r == 8'h00) &&  prev_down_r && prev_dut_rst_n_r;
  end

  // Lock FSM with all outputs registered; disable beats any compare result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      run_r            <= 4'd0;
      expected         <= 8'd0;
      prev_count_r     <= 8'd0;
      prev_down_r      <= 1'b0;
      prev_dut_rst_n_r <= 1'b0;
      locked           <= 1'b0;
      mismatch         <= 1'b0;
      err_sticky       <= 1'b0;
      err_cnt          <= '0;
      wrap_up          <= 1'b0;
      wrap_dn          <= 1'b0;
    end else if (!en) begin
      // expected, err_cnt and err_sticky deliberately hold here.
      state_r  <= ST_IDLE;
      run_r    <= 4'd0;
      locked   <= 1'b0;
      mismatch <= 1'b0;
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
    end else begin
      expected         <= pred_s;
      prev_count_r     <= count;
      prev_down_r      <= down;
      prev_dut_rst_n_r <= dut_rst_n;
      mismatch         <= 1'b0;
      wrap_up          <= 1'b0;
      wrap_dn          <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          // First enabled edge only seeds the prediction.
          state_r <= ST_SYNC;
          run_r   <= 4'd0;
          locked  <= 1'b0;
        end

        ST_SYNC: begin
          run_r <= 4'd0;
          if (hit_s) begin
            state_r <= ST_TRACK;
            locked  <= 1'b1;
          end else begin
            state_r <= ST_SYNC;
            locked  <= 1'b0;
          end
        end

        ST_TRACK: begin
          run_r <= 4'd0;
          if (hit_s) begin
            state_r <= ST_TRACK;
            locked  <= 1'b1;
            wrap_up <= wrap_up_hit_s;
            wrap_dn <= wrap_dn_hit_s;
          end else begin
            state_r    <= ST_RESYNC;
            locked     <= 1'b0;
            mismatch   <= 1'b1;
            err_cnt    <= err_inc_s;
            err_sticky <= 1'b1;
          end
        end

        ST_RESYNC: begin
          // Misses here only restart the run; they are not counted again.
          if (hit_s) begin
            if (run_inc_s == LOCK_TGT) begin
              state_r <= ST_TRACK;
              run_r   <= 4'd0;
              locked  <= 1'b1;
            end else begin
              state_r <= ST_RESYNC;
              run_r   <= run_inc_s;
              locked  <= 1'b0;
            end
          end else begin
            state_r <= ST_RESYNC;
            run_r   <= 4'd0;
            locked  <= 1'b0;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          run_r   <= 4'd0;
          locked  <= 1'b0;
        end
      endcase
    end
  end

  // Decode used only by the property checker below.
  always_comb begin
    state_is_track_s = (state_r == ST_TRACK);
  end

  count_monitor_checker u_checker (
    .clk            (clk),
    .rst_n          (rst_n),
    .locked         (locked),
    .mismatch       (mismatch),
    .wrap_up        (wrap_up),
    .wrap_dn        (wrap_dn),
    .state_is_track (state_is_track_s)
  );

endmodule

// Structural properties of the monitor outputs.
module count_monitor_checker (
  input logic clk,
  input logic rst_n,
  input logic locked,
  input logic mismatch,
  input logic wrap_up,
  input logic wrap_dn,
  input logic state_is_track
);

  a_event_excl: assert property (@(posedge clk) $onehot0({mismatch, wrap_up, wrap_dn}));
  a_mm_pulse:   assert property (@(posedge clk) disable iff (!rst_n) mismatch |=> !mismatch);
  a_wu_pulse:   assert property (@(posedge clk) disable iff (!rst_n) wrap_up |=> !wrap_up);
  a_wd_pulse:   assert property (@(posedge clk) disable iff (!rst_n) wrap_dn |=> !wrap_dn);
  a_lock_dec:   assert property (@(posedge clk) locked == state_is_track);

endmodule
